// File: rtl/in_channel.sv
// in_channel: host-fed circular input buffer serving the program's
// `inSize` / `in` instructions through a request/acknowledge port.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_OPEN    | host may still push words (sealed=0)
// ST_SEALED  | host closed the stream, words remain buffered
// ST_DRAINED | host closed the stream and the buffer is empty
module in_channel #(
  parameter int MemoryElementWidth = 12,
  parameter int NIn                = 8,
  parameter int PtrWidth           = 3,
  parameter int CountWidth         = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          hostValid,
  input  logic [MemoryElementWidth-1:0] hostData,
  output logic                          hostReady,
  input  logic                          hostClose,
  input  logic                          inReq,
  output logic [MemoryElementWidth-1:0] inData,
  output logic                          inAck,
  output logic                          inUnderflow,
  output logic [CountWidth-1:0]         inSize,
  output logic                          sealed,
  output logic                          drained
);

  typedef enum logic [1:0] {
    ST_OPEN    = 2'd0,
    ST_SEALED  = 2'd1,
    ST_DRAINED = 2'd2
  } chan_state_t;

  localparam logic [PtrWidth-1:0]   PtrLast  = PtrWidth'(NIn - 1);
  localparam logic [CountWidth-1:0] CountMax = CountWidth'(NIn);
  localparam logic [CountWidth-1:0] CountOne = CountWidth'(1);

  logic [MemoryElementWidth-1:0] mem [NIn];

  chan_state_t             st_q, st_d;
  logic [PtrWidth-1:0]     wr_ptr, rd_ptr;
  logic [CountWidth-1:0]   count_q, count_d;
  logic                    wr_fire, rd_fire, rd_empty;

  // Host may push only while open and not full; inReq never affects this.
  assign hostReady = !reset && (st_q == ST_OPEN) && (count_q < CountMax);

  assign wr_fire  = hostValid && hostReady;
  assign rd_fire  = inReq && (count_q != '0);
  assign rd_empty = inReq && (count_q == '0);

  assign inSize  = count_q;
  assign sealed  = (st_q != ST_OPEN);
  assign drained = (st_q == ST_DRAINED);

  // Occupancy after this edge: a simultaneous write and read cancel out.
  always_comb begin
    count_d = count_q;
    if (wr_fire && !rd_fire) begin
      count_d = count_q + CountOne;
    end else if (rd_fire && !wr_fire) begin
      count_d = count_q - CountOne;
    end
  end

  // Stream lifecycle: close seals, last read of a sealed stream drains it.
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_OPEN: begin
        if (hostClose) begin
          st_d = (count_d == '0) ? ST_DRAINED : ST_SEALED;
        end
      end
      ST_SEALED: begin
        if (count_d == '0) begin
          st_d = ST_DRAINED;
        end
      end
      ST_DRAINED: begin
        st_d = ST_DRAINED;
      end
      default: begin
        st_d = ST_OPEN;
      end
    endcase
  end

  // Lifecycle state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q <= ST_OPEN;
    end else begin
      st_q <= st_d;
    end
  end

  // Pointers wrap explicitly at NIn-1 so non-power-of-two depths work.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= (wr_ptr == PtrLast) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= (rd_ptr == PtrLast) ? '0 : rd_ptr + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Buffer storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem[wr_ptr] <= hostData;
    end
  end

  // Registered `in` response; an empty read keeps the last returned word.
  always_ff @(posedge clock) begin
    if (reset) begin
      inData      <= '0;
      inAck       <= 1'b0;
      inUnderflow <= 1'b0;
    end else begin
      inAck       <= inReq;
      inUnderflow <= rd_empty;
      if (rd_fire) begin
        inData <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_in_channel.sv
// Directed bench for in_channel built with a 4-deep buffer so the
// full and wrap cases are reached quickly.
module tb_in_channel;

  localparam int W  = 12;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          hostValid;
  logic [W-1:0]  hostData;
  logic          hostReady;
  logic          hostClose;
  logic          inReq;
  logic [W-1:0]  inData;
  logic          inAck;
  logic          inUnderflow;
  logic [CW-1:0] inSize;
  logic          sealed;
  logic          drained;

  int compared = 0;
  int mism     = 0;

  in_channel #(
    .MemoryElementWidth(W),
    .NIn(4),
    .PtrWidth(2),
    .CountWidth(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .hostValid(hostValid),
    .hostData(hostData),
    .hostReady(hostReady),
    .hostClose(hostClose),
    .inReq(inReq),
    .inData(inData),
    .inAck(inAck),
    .inUnderflow(inUnderflow),
    .inSize(inSize),
    .sealed(sealed),
    .drained(drained)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One `in` request, then check the acknowledged response.
  task automatic read_word(input string tag, input int exp_data, input int exp_uf,
                           input int exp_size);
    inReq = 1'b1;
    tick();
    inReq = 1'b0;
    chk({tag, "_ack"}, 32'(inAck), 32'd1);
    chk({tag, "_data"}, 32'(inData), 32'(exp_data));
    chk({tag, "_uf"}, 32'(inUnderflow), 32'(exp_uf));
    chk({tag, "_size"}, 32'(inSize), 32'(exp_size));
  endtask

  task automatic push(input int data);
    hostValid = 1'b1;
    hostData  = W'(data);
    tick();
    hostValid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; hostValid = 1'b0; hostData = '0; hostClose = 1'b0; inReq = 1'b0;
    tick();
    // reset state
    chk("rst_ready", 32'(hostReady), 32'd0);
    chk("rst_ack", 32'(inAck), 32'd0);
    chk("rst_size", 32'(inSize), 32'd0);
    chk("rst_sealed", 32'(sealed), 32'd0);
    chk("rst_data", 32'(inData), 32'd0);
    chk("rst_drained", 32'(drained), 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_ready", 32'(hostReady), 32'd1);

    // basic stream
    push(33);
    chk("bs_size1", 32'(inSize), 32'd1);
    push(22);
    push(11);
    chk("bs_size3", 32'(inSize), 32'd3);
    hostClose = 1'b1;
    tick();
    hostClose = 1'b0;
    chk("bs_sealed", 32'(sealed), 32'd1);
    chk("bs_ready_sealed", 32'(hostReady), 32'd0);
    chk("bs_not_drained", 32'(drained), 32'd0);
    read_word("bs_r0", 33, 0, 2);
    tick();
    chk("bs_ack_pulse", 32'(inAck), 32'd0);
    read_word("bs_r1", 22, 0, 1);
    tick();
    chk("bs_pre_drain", 32'(drained), 32'd0);
    read_word("bs_r2", 11, 0, 0);
    chk("bs_drained", 32'(drained), 32'd1);
    tick();
    // underflow on drained stream keeps last word
    read_word("uf_sealed", 11, 1, 0);
    tick();

    // reset out of drained state
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("r2_sealed", 32'(sealed), 32'd0);
    chk("r2_drained", 32'(drained), 32'd0);
    chk("r2_ready", 32'(hostReady), 32'd1);
    chk("r2_data", 32'(inData), 32'd0);

    // full / wrap
    push(1); push(2); push(3); push(4);
    chk("fw_size4", 32'(inSize), 32'd4);
    chk("fw_ready_full", 32'(hostReady), 32'd0);
    hostValid = 1'b1;
    hostData  = W'(5);
    tick();
    chk("fw_held_size", 32'(inSize), 32'd4);
    inReq = 1'b1;
    #1;
    chk("fw_ready_full_req", 32'(hostReady), 32'd0);
    tick();
    inReq = 1'b0;
    chk("fw_r1_data", 32'(inData), 32'd1);
    chk("fw_r1_size", 32'(inSize), 32'd3);
    chk("fw_ready_rise", 32'(hostReady), 32'd1);
    tick();
    hostValid = 1'b0;
    chk("fw_accept5", 32'(inSize), 32'd4);
    inReq = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("fw_b2b_ack", 32'(inAck), 32'd1);
      chk("fw_b2b_data", 32'(inData), 32'(i));
      chk("fw_b2b_size", 32'(inSize), 32'(5 - i));
    end
    inReq = 1'b0;
    tick();

    // underflow with inData last 7
    push(7);
    read_word("uf_prep", 7, 0, 0);
    read_word("uf", 7, 1, 0);
    tick();

    // simultaneous write + read at count 2
    push(20); push(21);
    hostValid = 1'b1; hostData = W'(9); inReq = 1'b1;
    tick();
    hostValid = 1'b0; inReq = 1'b0;
    chk("sim2_data", 32'(inData), 32'd20);
    chk("sim2_size", 32'(inSize), 32'd2);
    read_word("sim2_r1", 21, 0, 1);
    read_word("sim2_r2", 9, 0, 0);
    // simultaneous write + read at count 0
    hostValid = 1'b1; hostData = W'(13); inReq = 1'b1;
    tick();
    hostValid = 1'b0; inReq = 1'b0;
    chk("sim0_uf", 32'(inUnderflow), 32'd1);
    chk("sim0_data", 32'(inData), 32'd9);
    chk("sim0_size", 32'(inSize), 32'd1);
    read_word("sim0_r", 13, 0, 0);

    // close edge
    hostValid = 1'b1; hostData = W'(44); hostClose = 1'b1;
    tick();
    hostClose = 1'b0; hostData = W'(45);
    chk("ce_sealed", 32'(sealed), 32'd1);
    chk("ce_size", 32'(inSize), 32'd1);
    chk("ce_ready", 32'(hostReady), 32'd0);
    tick();
    hostValid = 1'b0;
    chk("ce_ignore45", 32'(inSize), 32'd1);
    read_word("ce_r", 44, 0, 0);
    chk("ce_drained", 32'(drained), 32'd1);

    // reset mid-operation with a request pending
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push(50); push(51); push(52);
    chk("rm_size3", 32'(inSize), 32'd3);
    inReq = 1'b1; reset = 1'b1;
    tick();
    inReq = 1'b0; reset = 1'b0;
    #1;
    chk("rm_ack", 32'(inAck), 32'd0);
    chk("rm_size", 32'(inSize), 32'd0);
    chk("rm_sealed", 32'(sealed), 32'd0);
    chk("rm_data", 32'(inData), 32'd0);
    chk("rm_ready", 32'(hostReady), 32'd1);
    push(60);
    read_word("rm_new", 60, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
